osc_period_monitor: RTL

- Parametrised successor to the two-oscillator simulation controller.
- Holds programmable t_lo/t_hi settings for NUM_OSC oscillator channels, in DT units, and drives them to the oscillators.
- Measures each channel's actual high and low durations by accumulating the emulator time step, checks them against the settings within a tolerance, and counts good periods.
- Raises per-channel done/error flags plus aggregate flags. Synthesizable, single clock domain, usable in emulation.

---
 rtl/osc_period_monitor_if.sv | 22 ++
 rtl/osc_period_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/osc_period_monitor_if.sv
// osc_period_monitor_if
//   Configuration write bus for osc_period_monitor.
//   Ports (signals):
//     cfg_we    write strobe
//     cfg_sel   0 = t_lo, 1 = t_hi
//     cfg_ch    channel index, max(1, clog2(NUM_OSC)) bits
//     cfg_data  value to write, W bits
//   Modports: master drives the bus, slave (the monitor) receives it.
interface osc_period_monitor_if #(
  parameter int NUM_OSC = 2,
  parameter int W       = 32
);
  localparam int CH_W = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;

  logic            cfg_we;
  logic            cfg_sel;
  logic [CH_W-1:0] cfg_ch;
  logic [W-1:0]    cfg_data;

  modport master (output cfg_we, cfg_sel, cfg_ch, cfg_data);
  modport slave  (input  cfg_we, cfg_sel, cfg_ch, cfg_data);
endinterface

// File: rtl/osc_period_monitor.sv
// osc_period_monitor
//   Holds programmable t_lo/t_hi settings for NUM_OSC oscillator channels and
//   measures each channel's high/low durations by accumulating dt per cycle.
//   Each measured phase is checked against its setting within +/-TOL; after
//   NUM_PERIODS good periods a channel reports done, on any bad phase it
//   reports done+err (sticky until clear or reset).
//
//   Optional feature: define OSC_PERIOD_MONITOR_TIMEOUT_EN to fail a channel
//   whose current phase exceeds twice its setting (or whose accumulator
//   saturates), catching stuck oscillators.
//
//   Ports:
//     clk       system clock
//     rst_n     asynchronous active-low reset
//     clear     synchronous restart of all channels (settings kept)
//     cfg       config write bus (osc_period_monitor_if.slave)
//     dt        emulator time step for this cycle
//     osc_val   sampled oscillator levels, one bit per channel
//     t_lo      packed t_lo settings, channel i at [i*W +: W]
//     t_hi      packed t_hi settings, channel i at [i*W +: W]
//     done      per-channel finished (pass or fail)
//     err       per-channel failed a check
//     all_done  every channel done
//     err_any   any channel in error
module osc_period_monitor #(
  parameter int             NUM_OSC     = 2,
  parameter int             W           = 32,
  parameter int             TOL         = 2,
  parameter int             NUM_PERIODS = 4,
  parameter logic [W-1:0]   T_LO_RST    = '0,
  parameter logic [W-1:0]   T_HI_RST    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  osc_period_monitor_if.slave    cfg,
  input  logic [W-1:0]           dt,
  input  logic [NUM_OSC-1:0]     osc_val,
  output logic [NUM_OSC*W-1:0]   t_lo,
  output logic [NUM_OSC*W-1:0]   t_hi,
  output logic [NUM_OSC-1:0]     done,
  output logic [NUM_OSC-1:0]     err,
  output logic                   all_done,
  output logic                   err_any
);

  localparam int CNT_W = $clog2(NUM_PERIODS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_PERIODS - 1);
  localparam logic signed [W:0] TOL_S    = (W + 1)'(TOL);

  typedef enum logic [2:0] {
    ARM,
    HI,
    LO,
    PASS,
    FAIL
  } state_t;

  state_t             state_q  [NUM_OSC];
  logic [W-1:0]       acc_q    [NUM_OSC];
  logic [CNT_W-1:0]   cnt_q    [NUM_OSC];
  logic [W-1:0]       t_lo_q   [NUM_OSC];
  logic [W-1:0]       t_hi_q   [NUM_OSC];
  logic [NUM_OSC-1:0] osc_prev_q;
  logic [NUM_OSC-1:0] done_q;
  logic [NUM_OSC-1:0] err_q;

  logic [NUM_OSC-1:0] rise;
  logic [NUM_OSC-1:0] fall;
  logic [NUM_OSC-1:0] hi_ok;
  logic [NUM_OSC-1:0] lo_ok;
  logic [NUM_OSC-1:0] tmo_hi;
  logic [NUM_OSC-1:0] tmo_lo;
  logic [W:0]         sum_w   [NUM_OSC];
  logic [W-1:0]       acc_inc [NUM_OSC];
  logic               cfg_ch_ok;

  // Signed W+1 bit difference so that neither operand order can wrap.
  function automatic logic within_tol(input logic [W-1:0] meas,
                                      input logic [W-1:0] setting);
    logic signed [W:0] diff;
    diff = $signed({1'b0, meas}) - $signed({1'b0, setting});
    return (diff <= TOL_S) && (diff >= -TOL_S);
  endfunction

  assign cfg_ch_ok = 32'(cfg.cfg_ch) < 32'(NUM_OSC);

  always_comb begin
    rise   = '0;
    fall   = '0;
    hi_ok  = '0;
    lo_ok  = '0;
    tmo_hi = '0;
    tmo_lo = '0;
    for (int unsigned i = 0; i < NUM_OSC; i++) begin
      rise[i]    = osc_val[i] & ~osc_prev_q[i];
      fall[i]    = ~osc_val[i] & osc_prev_q[i];
      sum_w[i]   = {1'b0, acc_q[i]} + {1'b0, dt};
      acc_inc[i] = sum_w[i][W] ? '1 : sum_w[i][W-1:0];
      hi_ok[i]   = within_tol(acc_q[i], t_hi_q[i]);
      lo_ok[i]   = within_tol(acc_q[i], t_lo_q[i]);
`ifdef OSC_PERIOD_MONITOR_TIMEOUT_EN
      tmo_hi[i]  = ({1'b0, acc_q[i]} > {t_hi_q[i], 1'b0}) || (&acc_q[i]);
      tmo_lo[i]  = ({1'b0, acc_q[i]} > {t_lo_q[i], 1'b0}) || (&acc_q[i]);
`else
      tmo_hi[i]  = 1'b0;
      tmo_lo[i]  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_OSC; i++) begin
        state_q[i] <= ARM;
        acc_q[i]   <= '0;
        cnt_q[i]   <= '0;
        t_lo_q[i]  <= T_LO_RST;
        t_hi_q[i]  <= T_HI_RST;
      end
      osc_prev_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      osc_prev_q <= osc_val;

      // Settings are written independently of clear and channel state.
      if (cfg.cfg_we && cfg_ch_ok) begin
        if (cfg.cfg_sel) t_hi_q[cfg.cfg_ch] <= cfg.cfg_data;
        else             t_lo_q[cfg.cfg_ch] <= cfg.cfg_data;
      end

      for (int unsigned i = 0; i < NUM_OSC; i++) begin
        if (clear) begin
          state_q[i] <= ARM;
          acc_q[i]   <= '0;
          cnt_q[i]   <= '0;
          done_q[i]  <= 1'b0;
          err_q[i]   <= 1'b0;
        end else begin
          // Each phase restarts at dt on its opening edge, so the checked
          // value is (cycles at level) * dt including the edge cycle.
          acc_q[i] <= (rise[i] | fall[i]) ? dt : acc_inc[i];

          unique case (state_q[i])
            ARM: begin
              if (rise[i]) state_q[i] <= HI;
            end
            HI: begin
              if (fall[i]) begin
                if (hi_ok[i]) begin
                  state_q[i] <= LO;
                end else begin
                  state_q[i] <= FAIL;
                  done_q[i]  <= 1'b1;
                  err_q[i]   <= 1'b1;
                end
              end else if (tmo_hi[i]) begin
                state_q[i] <= FAIL;
                done_q[i]  <= 1'b1;
                err_q[i]   <= 1'b1;
              end
            end
            LO: begin
              if (rise[i]) begin
                if (!lo_ok[i]) begin
                  state_q[i] <= FAIL;
                  done_q[i]  <= 1'b1;
                  err_q[i]   <= 1'b1;
                end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
                  if (cnt_q[i] == LAST_CNT) begin
                    state_q[i] <= PASS;
                    done_q[i]  <= 1'b1;
                  end else begin
                    state_q[i] <= HI;
                  end
                end
              end else if (tmo_lo[i]) begin
                state_q[i] <= FAIL;
                done_q[i]  <= 1'b1;
                err_q[i]   <= 1'b1;
              end
            end
            PASS, FAIL: begin
              state_q[i] <= state_q[i];
            end
            default: begin
              state_q[i] <= ARM;
            end
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OSC; g++) begin : g_pack
    assign t_lo[g*W +: W] = t_lo_q[g];
    assign t_hi[g*W +: W] = t_hi_q[g];
  end

  assign done     = done_q;
  assign err      = err_q;
  // Reductions of registered flags: they change in the same cycle as done/err.
  assign all_done = &done_q;
  assign err_any  = |err_q;

endmodule
